wb_memtest_master: RTL
======================

// Module: wb_memtest_master
// PURPOSE
// Wishbone master (initiator) that exercises a 16-bit SRAM-style slave: writes a generated
// pattern over a word range, reads the range back and compares. Drives one port of the SRAM
// slave (18-bit word address [18:1]), for power-on memory test and bring-up.
// Classic single cycles only.
// PARAMETERS
// TIMEOUT      255  cycles waiting for wbm_ack_i before abort (1..65535)
// STOP_ON_ERR  0    1 = end test at first miscompare; 0 = scan whole range
// PORTS
// wb_clk_i    in   1   clock
// wb_rst_n_i  in   1   synchronous active-low reset
// start_i     in   1   1-cycle start pulse; ignored while busy_o=1
// base_i      in   18  first word address, sampled at start
// len_i       in   18  word count, sampled at start; 0 = empty test
// mode_i      in   2   0 const seed, 1 seed+idx, 2 addr[16:1], 3 LFSR; sampled at start
// seed_i      in   16  pattern seed, sampled at start
// wbm_adr_o   out  18  word address [18:1]
// wbm_dat_o   out  16  write data
// wbm_dat_i   in   16  read data, valid on ack
// wbm_we_o    out  1   1 = write
// wbm_sel_o   out  2   byte lanes, always 2'b11 during a cycle
// wbm_stb_o   out  1   strobe
// wbm_cyc_o   out  1   cycle (always equal to wbm_stb_o)
// wbm_ack_i   in   1   slave ack
// busy_o      out  1   test in progress
// done_o      out  1   1-cycle completion pulse (pass, fail or timeout)
// err_o       out  1   sticky fail flag; cleared by next accepted start
// timeout_o   out  1   sticky ack-timeout flag; cleared by next accepted start
// err_cnt_o   out  16  miscompare count, saturates at 16'hFFFF
// err_adr_o   out  18  address of first miscompare
// err_dat_o   out  16  data read at first miscompare
// BEHAVIOUR
// - Reset (wb_rst_n_i=0 at posedge): all outputs 0, FSM -> IDLE; applies mid-transfer, so
//   stb/cyc drop on that edge and no further cycles are issued.
// - States: IDLE, WR, WGAP, RD, RGAP, FIN. All outputs registered.
// - IDLE + start_i: latch inputs, clear err/timeout/err_cnt/err_adr/err_dat, busy_o=1,
//   idx=0. len_i=0 -> FIN, no bus cycle; else -> WR.
// - WR: stb=cyc=we=1, adr=base+idx (mod 2^18), dat=pattern(idx). Held stable until ack
//   edge, then -> WGAP with stb=0.
// - WGAP: one idle cycle (stb=0). idx==len-1 -> RD with idx=0, pattern regenerated
//   from seed; else idx+1 -> WR.
// - RD: stb=cyc=1, we=0, same address rule. On ack edge compare wbm_dat_i to pattern(idx);
//   mismatch: err_o=1, err_cnt+1 (sat); first mismatch also loads err_adr_o/err_dat_o.
//   -> RGAP.
// - RGAP: one idle cycle. last idx, or mismatch with STOP_ON_ERR=1 -> FIN; else idx+1 -> RD.
// - FIN: done_o=1 one cycle, busy_o=0 on exit -> IDLE. Flags hold until next start.
// - Min 2 cycles per word for a 1-cycle-ack slave: stb never held across two
//   consecutive acks.
// - Timeout: counter cleared on WR/RD entry, +1 each cycle without ack; reaching
//   TIMEOUT -> stb=0, timeout_o=1, err_o=1, -> FIN. Ack at same edge as limit counts as ack.
// - Patterns (16-bit): mode0 seed; mode1 seed+idx[15:0] (wraps); mode2 adr[16:1];
//   mode3 Galois LFSR poly 0xB400, state starts at seed (0 replaced by 1),
//   steps once per word.
// - Address wraps at 2^18 (base+len beyond range wraps to 0).
// - start_i while busy_o=1: no effect. start_i on the FIN cycle: ignored.
// TESTING
// - Reset: wb_rst_n_i=0 2 cycles mid-WR -> stb/cyc/busy/err/done all 0 next edge.
// - Pass, mode1, base=18'h00010, len=4, seed=16'h1234, 1-cycle-ack model -> writes
//   1234..1237 at 10..13, reads back, done_o pulse, err_o=0, err_cnt_o=0.
// - Fail, mode0 seed=16'hA5A5, len=8, model flips bit0 at addr base+5 -> err_cnt_o=1,
//   err_adr_o=base+5, err_dat_o=16'hA5A4, err_o=1.
// - STOP_ON_ERR=1, same fault -> no read of base+6, done_o right after base+5 read.
// - Timeout, TIMEOUT=8, slave never acks -> stb held 8 cycles then 0, timeout_o=1,
//   err_o=1, done_o.
// - Edges: len=0 -> done_o with no stb; base=18'h3FFFE, len=4 -> adr 3FFFE,3FFFF,0,1;
//   mode3 seed=0 readback equals write sequence.

Source files
------------

// File: rtl/wb_memtest_master_if.sv
// Wishbone classic bus between the memory-test master and a 16-bit SRAM slave
// (18-bit word address).
interface wb_memtest_master_if;
    logic [17:0] wbm_adr_o;
    logic [15:0] wbm_dat_o;
    logic [15:0] wbm_dat_i;
    logic        wbm_we_o;
    logic [1:0]  wbm_sel_o;
    logic        wbm_stb_o;
    logic        wbm_cyc_o;
    logic        wbm_ack_i;

    modport master (
        output wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o, wbm_stb_o, wbm_cyc_o,
        input  wbm_dat_i, wbm_ack_i
    );

    modport slave (
        input  wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o, wbm_stb_o, wbm_cyc_o,
        output wbm_dat_i, wbm_ack_i
    );
endinterface

// File: rtl/wb_memtest_master.sv
// Wishbone memory-test master: writes a generated pattern over a word range, reads it
// back and compares, with ack timeout and sticky error reporting.
module wb_memtest_master #(
    parameter int TIMEOUT     = 255,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_n_i,
    input  logic                       start_i,
    input  logic [17:0]                base_i,
    input  logic [17:0]                len_i,
    input  logic [1:0]                 mode_i,
    input  logic [15:0]                seed_i,
    wb_memtest_master_if.master        wb,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o,
    output logic                       timeout_o,
    output logic [15:0]                err_cnt_o,
    output logic [17:0]                err_adr_o,
    output logic [15:0]                err_dat_o
);
    localparam logic [15:0] TMO_LIM = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_WR, S_WGAP, S_RD, S_RGAP, S_FIN} state_e;

    function automatic logic [15:0] lfsr_init(input logic [15:0] s);
        return (s == 16'd0) ? 16'd1 : s;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    function automatic logic [15:0] pat_f(input logic [1:0] m, input logic [15:0] s,
                                          input logic [15:0] i, input logic [15:0] a,
                                          input logic [15:0] l);
        logic [15:0] p;
        case (m)
            2'd0:    p = s;
            2'd1:    p = s + i;
            2'd2:    p = a;
            default: p = l;
        endcase
        return p;
    endfunction

    state_e      state_q, state_d;
    logic [17:0] base_q, base_d, len_q, len_d, idx_q, idx_d, adr_q, adr_d;
    logic [1:0]  mode_q, mode_d;
    logic [15:0] seed_q, seed_d, lfsr_q, lfsr_d, pat_q, pat_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d, err_cnt_q, err_cnt_d, err_dat_q, err_dat_d;
    logic [17:0] err_adr_q, err_adr_d;
    logic        stb_q, stb_d, we_q, we_d, busy_q, busy_d, done_q, done_d;
    logic        err_q, err_d, tmo_q, tmo_d, mis_q, mis_d;
    logic        load, load_we;
    logic        last_idx, tmo_hit, mismatch;

    assign last_idx = (idx_q == len_q - 18'd1);
    assign tmo_hit  = !wb.wbm_ack_i && (tmo_cnt_q == TMO_LIM);
    assign mismatch = (wb.wbm_dat_i != pat_q);

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            adr_q     <= '0;
            mode_q    <= '0;
            seed_q    <= '0;
            lfsr_q    <= '0;
            pat_q     <= '0;
            tmo_cnt_q <= '0;
            err_cnt_q <= '0;
            err_adr_q <= '0;
            err_dat_q <= '0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            tmo_q     <= 1'b0;
            mis_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            adr_q     <= adr_d;
            mode_q    <= mode_d;
            seed_q    <= seed_d;
            lfsr_q    <= lfsr_d;
            pat_q     <= pat_d;
            tmo_cnt_q <= tmo_cnt_d;
            err_cnt_q <= err_cnt_d;
            err_adr_q <= err_adr_d;
            err_dat_q <= err_dat_d;
            stb_q     <= stb_d;
            we_q      <= we_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
            mis_q     <= mis_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_i) state_d = (len_i == 18'd0) ? S_FIN : S_WR;
            S_WR: begin
                if (wb.wbm_ack_i)  state_d = S_WGAP;
                else if (tmo_hit)  state_d = S_FIN;
            end
            S_WGAP: state_d = last_idx ? S_RD : S_WR;
            S_RD: begin
                if (wb.wbm_ack_i)  state_d = S_RGAP;
                else if (tmo_hit)  state_d = S_FIN;
            end
            S_RGAP: state_d = (last_idx || (STOP_ON_ERR && mis_q)) ? S_FIN : S_RD;
            S_FIN:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        base_d    = base_q;
        len_d     = len_q;
        idx_d     = idx_q;
        adr_d     = adr_q;
        mode_d    = mode_q;
        seed_d    = seed_q;
        lfsr_d    = lfsr_q;
        pat_d     = pat_q;
        tmo_cnt_d = tmo_cnt_q;
        err_cnt_d = err_cnt_q;
        err_adr_d = err_adr_q;
        err_dat_d = err_dat_q;
        stb_d     = stb_q;
        we_d      = we_q;
        busy_d    = busy_q;
        err_d     = err_q;
        tmo_d     = tmo_q;
        mis_d     = mis_q;
        load      = 1'b0;
        load_we   = 1'b0;
        case (state_q)
            S_IDLE: if (start_i) begin
                base_d    = base_i;
                len_d     = len_i;
                mode_d    = mode_i;
                seed_d    = seed_i;
                idx_d     = '0;
                lfsr_d    = lfsr_init(seed_i);
                busy_d    = 1'b1;
                err_d     = 1'b0;
                tmo_d     = 1'b0;
                mis_d     = 1'b0;
                err_cnt_d = '0;
                err_adr_d = '0;
                err_dat_d = '0;
                load      = (len_i != 18'd0);
                load_we   = 1'b1;
            end
            S_WR, S_RD: begin
                if (wb.wbm_ack_i) begin
                    stb_d = 1'b0;
                    we_d  = 1'b0;
                    if (state_q == S_RD) begin
                        mis_d = mismatch;
                        // err_cnt still zero means this is the first miscompare of the run
                        if (mismatch) begin
                            err_d = 1'b1;
                            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
                            if (err_cnt_q == 16'd0) begin
                                err_adr_d = adr_q;
                                err_dat_d = wb.wbm_dat_i;
                            end
                        end
                    end
                end else if (tmo_hit) begin
                    stb_d = 1'b0;
                    we_d  = 1'b0;
                    tmo_d = 1'b1;
                    err_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end
            S_WGAP: begin
                load = 1'b1;
                if (last_idx) begin
                    idx_d   = '0;
                    lfsr_d  = lfsr_init(seed_q);
                    load_we = 1'b0;
                end else begin
                    idx_d   = idx_q + 18'd1;
                    lfsr_d  = lfsr_step(lfsr_q);
                    load_we = 1'b1;
                end
            end
            S_RGAP: if (state_d == S_RD) begin
                load    = 1'b1;
                idx_d   = idx_q + 18'd1;
                lfsr_d  = lfsr_step(lfsr_q);
                load_we = 1'b0;
            end
            S_FIN:   busy_d = 1'b0;
            default: ;
        endcase
        // Every bus cycle is launched from the next-state index so outputs stay registered
        if (load) begin
            adr_d     = base_d + idx_d;
            pat_d     = pat_f(mode_d, seed_d, idx_d[15:0], adr_d[15:0], lfsr_d);
            stb_d     = 1'b1;
            we_d      = load_we;
            tmo_cnt_d = '0;
        end
    end

    assign done_d = (state_d == S_FIN);

    assign wb.wbm_adr_o = adr_q;
    assign wb.wbm_dat_o = pat_q;
    assign wb.wbm_we_o  = we_q;
    assign wb.wbm_sel_o = {2{stb_q}};
    assign wb.wbm_stb_o = stb_q;
    assign wb.wbm_cyc_o = stb_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign timeout_o    = tmo_q;
    assign err_cnt_o    = err_cnt_q;
    assign err_adr_o    = err_adr_q;
    assign err_dat_o    = err_dat_q;
endmodule
